// File: rtl/aes_paket.sv
// aes_paket: AES-128 key schedule constants, word/state types and byte-rotation helper
package aes_paket;
   localparam int AES_NR = 10;
   localparam int AES_NK = 4;
   // Rcon indexed by round number; entry 0 and 11..15 are padding so any 4-bit index is safe
   localparam logic [15:0][7:0] AES_RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                            8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
   typedef logic [31:0] kelime_t;
   typedef enum logic [1:0] {BOS, URET, SON} durum_t;
   function automatic kelime_t rot_kelime(input kelime_t w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/s_kutusu.sv
// s_kutusu: combinational AES forward S-box, one byte in, one byte out
module s_kutusu (
   input  logic [7:0] i_bayt,
   output logic [7:0] o_bayt
);
   // Table stored with entry 0 in the top byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign o_bayt = SBOX[{~i_bayt, 3'b111} -: 8];
endmodule

// File: rtl/anahtar_genisletme.sv
// anahtar_genisletme: iterative AES-128 key schedule, round keys 0..10 over valid/ready; ANAHTAR_TERS_SIRA_EN adds reverse-order emission (keys 10..0)
module anahtar_genisletme
   import aes_paket::*;
#(
   parameter int NR     = 10,
   parameter int VERI_G = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              baslat,
`ifdef ANAHTAR_TERS_SIRA_EN
   input  logic              ters,
`endif
   input  logic [VERI_G-1:0] anahtar,
   output logic [VERI_G-1:0] tur_anahtari,
   output logic [3:0]        tur_no,
   output logic              gecerli,
   input  logic              hazir,
   output logic              mesgul,
   output logic              bitti
);
   if (NR != AES_NR || VERI_G != 128) begin : g_param_hatasi
      $error("anahtar_genisletme supports only AES-128 (NR=10, VERI_G=128)");
   end

   durum_t              r_durum;
   logic [VERI_G-1:0]   r_anahtar;
   logic [3:0]          r_tur;
   logic                r_gecerli;
   logic                r_bitti;
   logic                w_ters_giris;
   logic                w_geri;
   logic                w_hazirlik;
   logic                w_ters_adim;
   logic                w_el_sikisma;
   kelime_t             w_k0, w_k1, w_k2, w_k3;
   kelime_t             w_i3, w_sb_giris, w_sub, w_temp;
   kelime_t             w_n0, w_n1, w_n2;
   logic [7:0]          w_rcon;
   logic [3:0]          w_son;
   logic [127:0]        w_ileri, w_geri_adim, w_adim;

`ifdef ANAHTAR_TERS_SIRA_EN
   logic r_ters;
   logic r_hazirlik;
   assign w_ters_giris = ters;
   assign w_geri       = r_ters;
   assign w_hazirlik   = r_hazirlik;
   // Direction latched at start; reverse mode first walks forward until key 10 exists
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ters     <= 1'b0;
         r_hazirlik <= 1'b0;
      end else if (r_durum == BOS && baslat) begin
         r_ters     <= ters;
         r_hazirlik <= ters;
      end else if (r_hazirlik && r_tur == 4'(NR - 1)) begin
         r_hazirlik <= 1'b0;
      end
   end
`else
   assign w_ters_giris = 1'b0;
   assign w_geri       = 1'b0;
   assign w_hazirlik   = 1'b0;
`endif

   assign {w_k0, w_k1, w_k2, w_k3} = r_anahtar;
   assign w_ters_adim  = w_geri && !w_hazirlik;
   assign w_el_sikisma = r_gecerli && hazir;
   assign w_son        = w_geri ? 4'd0 : 4'(NR);

   // The inverse step needs SubWord of the recovered w3, so the S-box input is muxed
   assign w_i3       = w_k3 ^ w_k2;
   assign w_sb_giris = rot_kelime(w_ters_adim ? w_i3 : w_k3);
   assign w_rcon     = AES_RCON[w_ters_adim ? r_tur : r_tur + 4'd1];
   assign w_temp     = w_sub ^ {w_rcon, 24'h0};

   for (genvar i = 0; i < AES_NK; i++) begin : g_sbox
      s_kutusu u_sbox (
         .i_bayt (w_sb_giris[8*i +: 8]),
         .o_bayt (w_sub[8*i +: 8])
      );
   end

   assign w_n0        = w_k0 ^ w_temp;
   assign w_n1        = w_k1 ^ w_n0;
   assign w_n2        = w_k2 ^ w_n1;
   assign w_ileri     = {w_n0, w_n1, w_n2, w_k3 ^ w_n2};
   assign w_geri_adim = {w_k0 ^ w_temp, w_k1 ^ w_k0, w_k2 ^ w_k1, w_i3};
   assign w_adim      = w_ters_adim ? w_geri_adim : w_ileri;

   // Control FSM: load on start, advance one round per accepted key, pulse bitti after the last
   always_ff @(posedge clk) begin
      if (rst) begin
         r_durum   <= BOS;
         r_anahtar <= '0;
         r_tur     <= '0;
         r_gecerli <= 1'b0;
         r_bitti   <= 1'b0;
      end else begin
         case (r_durum)
            BOS: if (baslat) begin
               r_anahtar <= anahtar;
               r_tur     <= '0;
               r_gecerli <= !w_ters_giris;
               r_durum   <= URET;
            end
            URET: if (w_hazirlik) begin
               r_anahtar <= w_adim;
               r_tur     <= r_tur + 4'd1;
               r_gecerli <= (r_tur == 4'(NR - 1));
            end else if (w_el_sikisma) begin
               if (r_tur == w_son) begin
                  r_gecerli <= 1'b0;
                  r_bitti   <= 1'b1;
                  r_durum   <= SON;
               end else begin
                  r_anahtar <= w_adim;
                  r_tur     <= w_geri ? r_tur - 4'd1 : r_tur + 4'd1;
               end
            end
            SON: begin
               r_bitti <= 1'b0;
               r_durum <= BOS;
            end
            default: r_durum <= BOS;
         endcase
      end
   end

   assign tur_anahtari = r_anahtar;
   assign tur_no       = r_tur;
   assign gecerli      = r_gecerli;
   assign mesgul       = (r_durum != BOS);
   assign bitti        = r_bitti;
endmodule

// File: doc/anahtar_genisletme.md
Name: anahtar_genisletme

Overview:
- Iterative AES-128 key schedule; the stage directly upstream of the AddRoundKey block (Anahtar_Ekleme).
- Latches a 128-bit cipher key on a start pulse and emits round keys 0..10 one at a time.
- Uses a valid/ready handshake so the round controller consumes each key exactly once.
- Round key i (i=0..10) feeds the AddRoundKey key input for round i.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is legal; elaboration error otherwise.
- VERI_G, 128, key/state width in bits; fixed at 128.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- baslat  input  1  start pulse; sampled only in BOS.
- anahtar  input  128  cipher key; word w0=[127:96] … w3=[31:0]; byte 0 = [127:120].
- tur_anahtari  output  128  current round key.
- tur_no  output  4  index of the round key on tur_anahtari, 0..10.
- gecerli  output  1  tur_anahtari/tur_no valid.
- hazir  input  1  consumer ready; handshake = gecerli & hazir.
- mesgul  output  1  high in every state except BOS.
- bitti  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (rst=1 at a clk edge): state BOS; tur_anahtari=0, tur_no=0, gecerli=0, mesgul=0, bitti=0. Reset mid-sequence aborts immediately; no further keys are emitted.
- States: BOS, URET, SON.
- BOS: baslat=1 loads anahtar into the key register, sets tur_no=0, moves to URET. Next cycle: gecerli=1 with round key 0 (latency 1).
- URET, handshake with tur_no<10: register <= next(key); tur_no++; gecerli stays 1. With hazir held high, keys 0..10 appear on 11 consecutive cycles.
- URET, handshake with tur_no=10: gecerli<=0, bitti<=1, go to SON.
- SON: lasts one cycle (bitti=1), then returns to BOS with bitti=0. tur_anahtari holds its last value.
- URET without a handshake: tur_anahtari, tur_no and gecerli hold stable (AXI-style; no retraction).
- baslat outside BOS is ignored, including in the cycle of the final handshake.
- next(): temp = SubWord(RotWord(w3)) ^ {Rcon[i+1],24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. All XOR is bitwise, 32-bit.
- RotWord rotates left by one byte. Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- One combinational round step per cycle: 4 parallel S-box instances.

Optional Feature:
- Macro: ANAHTAR_TERS_SIRA_EN.
- Defined: adds input ters (1 bit, sampled with baslat). With ters=1, the block runs NR forward steps internally (mesgul=1, gecerli=0; first valid 11 cycles after baslat). It then emits keys 10 down to 0, tur_no decrementing, using the inverse step:
  - w3=w3'^w2'; w2=w2'^w1'; w1=w1'^w0'; w0=w0'^SubWord(RotWord(w3))^Rcon[i].
  - bitti pulses after key 0 is accepted.
- ters=0, or macro undefined: forward behaviour only; the port is absent when the macro is undefined.

Decomposition:
- Shared package aes_paket: AES_NR=10, AES_NK=4, the Rcon constant array, a 32-bit word typedef, and the state enum {BOS,URET,SON}.
- One sub-module, s_kutusu: 8-bit combinational forward S-box, instantiated 4 times for SubWord.
- The future SubBytes stage reuses s_kutusu.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, hazir=1 -> tur_no=1 gives a0fafe1788542cb123a339392a6c7605; tur_no=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; bitti one cycle after key 10; 11 consecutive valid cycles.
- Key 5468617473206D79204B756E67204675 -> key0 equals the input; key1 E232FCF191129188B159E4E6D679A293; key10 28FDDEF86DA4244ACCC0A4FE3B316F26.
- Backpressure: toggle hazir pseudo-randomly -> outputs stable while gecerli&!hazir; exactly 11 handshakes; the same key sequence as with hazir=1.
- baslat pulsed during URET with a different key -> ignored; the sequence is unchanged; mesgul=1 throughout.
- rst asserted at tur_no=5 -> next cycle gecerli=0, tur_no=0, mesgul=0. A fresh baslat then restarts from key 0.
- ANAHTAR_TERS_SIRA_EN with ters=1 and the FIPS key -> first valid is tur_no=10 = d014f9a8…0ca6; last is tur_no=0 = 2b7e…4f3c; bitti follows.
